// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default frame geometry,
// common to the transmitter and the receiver.
package uart_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_SAMPLING_RATE = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter that pulses tick for one cycle every
// SAMPLING_RATE enabled cycles; restart reloads it to a full bit period.
module uart_baud_tick #(
   parameter int SAMPLING_RATE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic en,
   output logic tick
);

   localparam int CW = (SAMPLING_RATE > 1) ? $clog2(SAMPLING_RATE) : 1;
   localparam logic [CW-1:0] TC_LOAD = CW'(SAMPLING_RATE - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= TC_LOAD;
      end else if (en) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_os.sv
// Oversampled-clock UART transmitter with a one-entry holding register so a
// second frame can be queued while the current one is on the line.
//
// state     | meaning
// IDLE      | line high, waiting for the holding register to fill
// START_BIT | start bit (0) for one bit period
// DATA      | data bits, LSB first, one bit period each
// PARITY    | even-parity bit, only when requested with the frame
// STOP      | stop bit (1); chains straight into the next frame if one is held
module uart_tx_os
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int SAMPLING_RATE = DEF_SAMPLING_RATE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  parity,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx,
   output logic                  ready,
   output logic                  done
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   uart_state_t state, state_nxt;

   logic                  hold_full;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_par;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  par_bit;
   logic                  par_en;
   logic [BW-1:0]         bit_cnt;
   logic                  tx_q, ready_q, done_q;

   logic tick, baud_en, baud_restart;
   logic load, frame_end, tx_nxt, accept;

   assign accept = start && ready_q;
   assign tx     = tx_q;
   assign ready  = ready_q;
   assign done   = done_q;

   uart_baud_tick #(
      .SAMPLING_RATE(SAMPLING_RATE)
   ) u_baud_tick (
      .clk    (clk),
      .rst    (rst),
      .restart(baud_restart),
      .en     (baud_en),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      load         = 1'b0;
      frame_end    = 1'b0;
      baud_en      = 1'b1;
      baud_restart = 1'b0;
      tx_nxt       = 1'b1;
      case (state)
         IDLE: begin
            baud_en      = 1'b0;
            baud_restart = 1'b1;
            if (hold_full) begin
               state_nxt = START_BIT;
               load      = 1'b1;
            end
         end
         START_BIT: begin
            tx_nxt = 1'b0;
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            tx_nxt = shift_reg[0];
            if (tick && (bit_cnt == LAST_BIT)) state_nxt = par_en ? PARITY : STOP;
         end
         PARITY: begin
            tx_nxt = par_bit;
            if (tick) state_nxt = STOP;
         end
         STOP: begin
            if (tick) begin
               frame_end = 1'b1;
               if (hold_full) begin
                  state_nxt = START_BIT;
                  load      = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // tx and done lag the state by one cycle so both come straight from flops
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         hold_par  <= 1'b0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
         par_en    <= 1'b0;
         bit_cnt   <= '0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         tx_q    <= tx_nxt;
         done_q  <= frame_end;
         ready_q <= !(accept || (hold_full && !load));
         if (accept) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
            hold_par  <= parity;
         end else if (load) begin
            hold_full <= 1'b0;
         end
         if (load) begin
            shift_reg <= hold_data;
            par_bit   <= ^hold_data;
            par_en    <= hold_par;
            bit_cnt   <= '0;
         end else if ((state == DATA) && tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_os.sv
// Self-checking bench for uart_tx_os: expected line waveforms are built from
// the frame definition (start, data LSB first, optional even parity, stop).
module tb_uart_tx_os;

   localparam int DW  = 8;
   localparam int SR  = 16;
   localparam int CAP = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          parity = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          tx, ready, done;

   int n_checks = 0;
   int n_errors = 0;

   logic cap_tx [CAP];
   logic cap_done [CAP];
   logic cap_ready [CAP];
   logic exp_tx [CAP];
   logic exp_done [CAP];

   uart_tx_os #(
      .DATA_WIDTH   (DW),
      .SAMPLING_RATE(SR)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .parity (parity),
      .tx_data(tx_data),
      .tx     (tx),
      .ready  (ready),
      .done   (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic int frame_len(input logic p);
      return (2 + DW + (p ? 1 : 0)) * SR;
   endfunction

   task automatic exp_clear();
      for (int i = 0; i < CAP; i++) begin
         exp_tx[i]   = 1'b1;
         exp_done[i] = 1'b0;
      end
   endtask

   // Reference model: one frame laid out bit by bit, each bit SR cycles wide
   task automatic exp_frame(input logic [DW-1:0] d, input logic p, input int base);
      logic bits[$];
      int   n;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (p) bits.push_back(^d);
      bits.push_back(1'b1);
      n = base;
      foreach (bits[b]) begin
         for (int k = 0; k < SR; k++) begin
            exp_tx[n] = bits[b];
            n++;
         end
      end
      exp_done[n-1] = 1'b1;
   endtask

   task automatic record(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cap_tx[i]    = tx;
         cap_done[i]  = done;
         cap_ready[i] = ready;
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic p);
      int waited = 0;
      while (ready !== 1'b1 && waited < 2000) begin
         @(posedge clk);
         #1;
         waited++;
      end
      n_checks++;
      if (ready !== 1'b1) begin
         n_errors++;
         $display("FAIL send_wait: ready=%b after %0d cycles, required 1", ready, waited);
      end
      start   = 1'b1;
      tx_data = d;
      parity  = p;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({tx, ready, done} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_state: tx,ready,done=%b, required 100", {tx, ready, done});
         end
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({tx, ready, done} !== 3'b110) begin
         n_errors++;
         $display("FAIL reset_release: tx,ready,done=%b, required 110", {tx, ready, done});
      end
   endtask

   task automatic test_waveform();
      int n;
      n = 1 + frame_len(1'b0) + 8;
      send(8'h01, 1'b0);
      n_checks++;
      if (ready !== 1'b0) begin
         n_errors++;
         $display("FAIL ready_after_accept: ready=%b, required 0", ready);
      end
      record(n);
      exp_clear();
      exp_frame(8'h01, 1'b0, 1);
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_done[i] !== exp_done[i]) begin
            n_errors++;
            $display("FAIL wave_01[%0d]: tx=%b done=%b, required tx=%b done=%b",
                     i, cap_tx[i], cap_done[i], exp_tx[i], exp_done[i]);
         end
      end
      n_checks++;
      if (cap_tx[1] !== 1'b0 || cap_done[160] !== 1'b1) begin
         n_errors++;
         $display("FAIL latency_01: first low=%b done@160=%b, required 0 and 1", cap_tx[1], cap_done[160]);
      end
      n_checks++;
      if (cap_ready[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL ready_after_transfer: ready=%b, required 1", cap_ready[1]);
      end
   endtask

   task automatic test_parity();
      logic [DW-1:0] pd [2];
      logic          pb [2];
      int            n;
      pd = '{8'h07, 8'h03};
      pb = '{1'b1, 1'b0};
      n  = 1 + frame_len(1'b1) + 4;
      for (int t = 0; t < 2; t++) begin
         send(pd[t], 1'b1);
         record(n);
         exp_clear();
         exp_frame(pd[t], 1'b1, 1);
         for (int i = 0; i < n; i++) begin
            n_checks++;
            if (cap_tx[i] !== exp_tx[i] || cap_done[i] !== exp_done[i]) begin
               n_errors++;
               $display("FAIL wave_parity_%h[%0d]: tx=%b done=%b, required tx=%b done=%b",
                        pd[t], i, cap_tx[i], cap_done[i], exp_tx[i], exp_done[i]);
            end
         end
         n_checks++;
         if (cap_tx[1 + 9*SR + SR/2] !== pb[t]) begin
            n_errors++;
            $display("FAIL parity_bit_%h: got %b, required %b", pd[t], cap_tx[1 + 9*SR + SR/2], pb[t]);
         end
         n_checks++;
         if (cap_done[176] !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_len_%h: done@176=%b, required 1", pd[t], cap_done[176]);
         end
      end
   endtask

   task automatic test_loopback();
      logic [DW-1:0] rx;
      int            dones;
      int            n;
      n     = 1 + frame_len(1'b1) + 8;
      dones = 0;
      send(8'hA5, 1'b1);
      record(n);
      for (int i = 0; i < n; i++) if (cap_done[i] === 1'b1) dones++;
      for (int i = 0; i < DW; i++) rx[i] = cap_tx[1 + (1 + i)*SR + SR/2];
      n_checks++;
      if (cap_tx[1 + SR/2] !== 1'b0 || cap_tx[1 + 10*SR + SR/2] !== 1'b1) begin
         n_errors++;
         $display("FAIL loopback_framing: start=%b stop=%b, required 0 and 1",
                  cap_tx[1 + SR/2], cap_tx[1 + 10*SR + SR/2]);
      end
      n_checks++;
      if (rx !== 8'hA5) begin
         n_errors++;
         $display("FAIL loopback_data: rx=%h, required a5", rx);
      end
      n_checks++;
      if (cap_tx[1 + 9*SR + SR/2] !== ^rx) begin
         n_errors++;
         $display("FAIL loopback_parity: got %b, required %b", cap_tx[1 + 9*SR + SR/2], ^rx);
      end
      n_checks++;
      if (dones != 1) begin
         n_errors++;
         $display("FAIL loopback_done: %0d pulses, required 1", dones);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      logic          p;
      int            n;
      repeat (6) begin
         d = DW'($urandom);
         p = 1'($urandom_range(0, 1));
         n = 1 + frame_len(p) + 4;
         send(d, p);
         record(n);
         exp_clear();
         exp_frame(d, p, 1);
         for (int i = 0; i < n; i++) begin
            n_checks++;
            if (cap_tx[i] !== exp_tx[i] || cap_done[i] !== exp_done[i]) begin
               n_errors++;
               $display("FAIL wave_rand_%h_p%b[%0d]: tx=%b done=%b, required tx=%b done=%b",
                        d, p, i, cap_tx[i], cap_done[i], exp_tx[i], exp_done[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic p2;
      int   n;
      int   dones;
      p2    = 1'($urandom_range(0, 1));
      n     = 1 + frame_len(1'b0) + frame_len(p2) + 8;
      dones = 0;
      send(8'h55, 1'b0);
      fork
         record(n);
         send(8'hAA, p2);
      join
      exp_clear();
      exp_frame(8'h55, 1'b0, 1);
      exp_frame(8'hAA, p2, 1 + frame_len(1'b0));
      for (int i = 0; i < n; i++) begin
         if (cap_done[i] === 1'b1) dones++;
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_done[i] !== exp_done[i]) begin
            n_errors++;
            $display("FAIL wave_b2b[%0d]: tx=%b done=%b, required tx=%b done=%b",
                     i, cap_tx[i], cap_done[i], exp_tx[i], exp_done[i]);
         end
      end
      n_checks++;
      if (dones != 2) begin
         n_errors++;
         $display("FAIL b2b_done: %0d pulses, required 2", dones);
      end
   endtask

   task automatic test_ignored_start();
      logic [DW-1:0] dx, dy;
      int            n;
      dx = DW'($urandom);
      dy = DW'($urandom);
      n  = 1 + frame_len(1'b0) + frame_len(1'b1) + 40;
      send(dx, 1'b0);
      fork
         record(n);
         begin
            send(dy, 1'b1);
            start   = 1'b1;
            tx_data = ~dy;
            parity  = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            start = 1'b0;
         end
      join
      exp_clear();
      exp_frame(dx, 1'b0, 1);
      exp_frame(dy, 1'b1, 1 + frame_len(1'b0));
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_done[i] !== exp_done[i]) begin
            n_errors++;
            $display("FAIL wave_ignored[%0d]: tx=%b done=%b, required tx=%b done=%b",
                     i, cap_tx[i], cap_done[i], exp_tx[i], exp_done[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      int            n;
      d = DW'($urandom);
      send(d, 1'b0);
      send(DW'($urandom), 1'b0);
      repeat (70) @(posedge clk);
      #1;
      n_checks++;
      if (tx !== d[3]) begin
         n_errors++;
         $display("FAIL mid_bit3: tx=%b, required %b", tx, d[3]);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({tx, ready, done} !== 3'b100) begin
         n_errors++;
         $display("FAIL mid_reset_state: tx,ready,done=%b, required 100", {tx, ready, done});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({tx, ready, done} !== 3'b110) begin
         n_errors++;
         $display("FAIL mid_reset_release: tx,ready,done=%b, required 110", {tx, ready, done});
      end
      record(300);
      for (int i = 0; i < 300; i++) begin
         n_checks++;
         if (cap_tx[i] !== 1'b1 || cap_done[i] !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle[%0d]: tx=%b done=%b, required tx=1 done=0", i, cap_tx[i], cap_done[i]);
         end
      end
      n = 1 + frame_len(1'b0) + 4;
      send(8'h3C, 1'b0);
      record(n);
      exp_clear();
      exp_frame(8'h3C, 1'b0, 1);
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_done[i] !== exp_done[i]) begin
            n_errors++;
            $display("FAIL wave_3c[%0d]: tx=%b done=%b, required tx=%b done=%b",
                     i, cap_tx[i], cap_done[i], exp_tx[i], exp_done[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_waveform();
      test_parity();
      test_loopback();
      test_random();
      test_back_to_back();
      test_ignored_start();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_os.md
UART_TX_OS -- requirements
Module: uart_tx_os

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter SAMPLING_RATE, default 16, clk cycles per bit period (same clock as uart_rx).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to send; accepted only when ready=1.
REQ-006 SHALL have port parity  input  1  1 = append even-parity bit to this frame; sampled with start.
REQ-007 SHALL have port tx_data  input  DATA_WIDTH  byte to send; sampled with start.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port ready  output  1  holding register empty, start will be accepted.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL be the oversampled-clock transmit counterpart of uart_rx: frame = start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit 1.
REQ-012 SHALL hold every bit on tx for exactly SAMPLING_RATE clk cycles; frame length = (2 + DATA_WIDTH + parity) * SAMPLING_RATE cycles.
REQ-013 Parity bit SHALL equal XOR of captured data bits (even parity); omitted entirely when captured parity=0.
REQ-014 Handshake: start && ready at edge N captures tx_data and parity into a one-entry holding register; ready=0 from cycle N+1 while the holding register is occupied.
REQ-015 start while ready=0 SHALL be ignored; no state change.
REQ-016 FSM states IDLE, START_BIT, DATA, PARITY, STOP; IDLE->START_BIT when holding register full; START_BIT->DATA after SAMPLING_RATE cycles; DATA->PARITY or STOP after bit DATA_WIDTH-1; PARITY->STOP; STOP->START_BIT if holding full, else IDLE.
REQ-017 Latency: from IDLE, start accepted at edge N SHALL drive tx=0 from edge N+2 (one cycle hold-to-shifter transfer).
REQ-018 Transfer from holding register to shifter SHALL set ready=1 on the following cycle, permitting a second request while the first frame is in flight.
REQ-019 Back-to-back: if holding register full when STOP finishes, next start bit SHALL begin the very next cycle, no idle gap.
REQ-020 done SHALL pulse high for exactly one cycle, in the last cycle of the stop bit, once per frame.
REQ-021 start accepted in the same cycle the holding register is emptied SHALL NOT occur (ready=0 that cycle); no data loss or duplication.
REQ-022 Bit counter SHALL be width $clog2(DATA_WIDTH), tick counter $clog2(SAMPLING_RATE); neither SHALL wrap mid-bit.
REQ-023 tx SHALL be registered, glitch-free, and 1 in IDLE.

Reset
REQ-024 On rst=1 at a clk edge: tx=1, ready=0, done=0, state IDLE, holding register empty, counters 0.
REQ-025 ready SHALL become 1 the first cycle after rst deasserts.
REQ-026 rst mid-frame SHALL abort the frame immediately (tx=1 next cycle), discard held data, no done pulse.

Structure
REQ-027 State enum and default DATA_WIDTH/SAMPLING_RATE constants SHALL live in shared package uart_pkg, reused by uart_rx.
REQ-028 Bit-period tick generation SHALL be one sub-module uart_baud_tick (counts SAMPLING_RATE cycles, outputs one-cycle tick, restartable).

Verification
REQ-029 Loopback to uart_rx (SAMPLING_RATE=16, NUM_POLLS=4): tx_data=8'hA5, parity=1 -> rx data=8'hA5, valid=1, one done pulse each side.
REQ-030 Waveform check: tx_data=8'h01, parity=0 -> tx low 16 cycles, high 16, low 112, high 16; frame 160 cycles; done in cycle 160.
REQ-031 Parity: tx_data=8'h07, parity=1 -> parity bit=1, frame 176 cycles; tx_data=8'h03 -> parity bit=0.
REQ-032 Back-to-back: send 8'h55 then 8'hAA as soon as ready reasserts -> second start bit immediately after first stop bit, both received correctly.
REQ-033 Ignored start: pulse start with ready=0 -> no extra frame, holding data unchanged.
REQ-034 Reset mid-data bit 3 -> tx=1 next cycle, no done, ready=1 after rst release, next frame 8'h3C sent correctly.
